// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// Keeps the single-cycle decoder's ALUOP, size and jump code values.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_BRANCH, CLS_J, CLS_JAL, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_ILLEGAL
    } op_class_t;

    localparam int OP_RTYPE = 0;
    localparam int OP_BLTZ  = 1;
    localparam int OP_J     = 2;
    localparam int OP_JAL   = 3;
    localparam int OP_BEQ   = 4;
    localparam int OP_BNE   = 5;
    localparam int OP_ADDI  = 8;
    localparam int OP_SLTI  = 10;
    localparam int OP_ANDI  = 12;
    localparam int OP_ORI   = 13;
    localparam int OP_XORI  = 14;
    localparam int OP_LB    = 32;
    localparam int OP_LH    = 33;
    localparam int OP_LW    = 35;
    localparam int OP_SB    = 40;
    localparam int OP_SH    = 41;
    localparam int OP_SW    = 43;

    localparam logic [1:0] SIZE_NONE = 2'd0;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;
    localparam logic [1:0] SIZE_WORD = 2'd3;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_SEXT  = 2'd2;
    localparam logic [1:0] SRCB_SHIFT = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] JMP_NONE  = 2'd0;
    localparam logic [1:0] JMP_JAL   = 2'd1;
    localparam logic [1:0] JMP_RTYPE = 2'd2;
    localparam logic [1:0] JMP_J     = 2'd3;

endpackage

// File: rtl/opcode_class_decode.sv
// opcode_class_decode: opcode -> instruction class and memory access size code.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure decode.
module opcode_class_decode
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic [1:0]          size_code
);

    always_comb begin
        op_class  = CLS_ILLEGAL;
        size_code = SIZE_NONE;
        case (opcode)
            OPCODE_W'(OP_RTYPE):                                    op_class = CLS_R;
            OPCODE_W'(OP_BLTZ), OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE): op_class = CLS_BRANCH;
            OPCODE_W'(OP_J):                                        op_class = CLS_J;
            OPCODE_W'(OP_JAL):                                      op_class = CLS_JAL;
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_SLTI), OPCODE_W'(OP_ANDI),
            OPCODE_W'(OP_ORI), OPCODE_W'(OP_XORI):                  op_class = CLS_IMM;
            OPCODE_W'(OP_LB): begin op_class = CLS_LOAD;  size_code = SIZE_BYTE; end
            OPCODE_W'(OP_LH): begin op_class = CLS_LOAD;  size_code = SIZE_HALF; end
            OPCODE_W'(OP_LW): begin op_class = CLS_LOAD;  size_code = SIZE_WORD; end
            OPCODE_W'(OP_SB): begin op_class = CLS_STORE; size_code = SIZE_BYTE; end
            OPCODE_W'(OP_SH): begin op_class = CLS_STORE; size_code = SIZE_HALF; end
            OPCODE_W'(OP_SW): begin op_class = CLS_STORE; size_code = SIZE_WORD; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multi-cycle sequencer, Moore control outputs from registered state + opcode.
// Latency: R/IMM 4, LOAD 5, STORE 4, BRANCH/J/JAL 3 cycles, plus 1 per memory wait cycle.
// Backpressure: mem_ready stretches FETCH/MEM_RD/MEM_WR; stall freezes state and masks all write strobes.
// Build option MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes park in TRAP instead of retiring as NOPs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 7,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic [1:0]          jump,
    output logic [1:0]          mem_read,
    output logic [1:0]          mem_write,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state
);

    state_t             state_q, state_d;
    op_class_t          op_class;
    logic [1:0]         size_code;
    logic               retire;
    logic [CNT_W-1:0]   retired_q;
    logic [ALUOP_W-1:0] alu_op_imm;

    opcode_class_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode    (opcode),
        .op_class  (op_class),
        .size_code (size_code)
    );

    assign alu_op_imm = ALUOP_W'({1'b1, opcode});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = '0;
        pc_source     = PCSRC_ALU;
        jump          = JMP_NONE;
        mem_read      = SIZE_NONE;
        mem_write     = SIZE_NONE;
        case (state_q)
            ST_FETCH: begin
                mem_read  = SIZE_WORD;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_SHIFT;
                case (op_class)
                    CLS_R:                state_d = ST_EXEC_R;
                    CLS_IMM:              state_d = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_d = ST_MEM_ADDR;
                    CLS_BRANCH:           state_d = ST_BRANCH;
                    CLS_J, CLS_JAL:       state_d = ST_JUMP;
                    default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                jump      = JMP_RTYPE;
                state_d   = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                jump      = JMP_RTYPE;
                state_d   = ST_FETCH;
                retire    = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
                alu_op    = alu_op_imm;
                state_d   = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
                retire    = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_b = SRCB_SEXT;
                alu_op    = alu_op_imm;
                state_d   = (op_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = size_code;
                if (mem_ready) state_d = ST_WB_MEM;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
                retire     = 1'b1;
            end
            ST_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = size_code;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_BRANCH: begin
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                alu_op        = alu_op_imm;
                state_d       = ST_FETCH;
                retire        = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                if (op_class == CLS_JAL) begin
                    jump      = JMP_JAL;
                    reg_write = 1'b1;
                end else begin
                    jump = JMP_J;
                end
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase
        // stall outranks everything, including a mem_ready that arrives during it
        if (stall) begin
            state_d       = state_q;
            retire        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            mem_write     = SIZE_NONE;
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  illegal_q <= 1'b0;
        else if (state_d == ST_TRAP)   illegal_q <= 1'b1;
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: hand-computed latency table, directed traces and randomized traces
// checked cycle by cycle against a per-instruction phase model built from the opcode classes.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        mem_ready, stall;
    logic        ir_write, pc_write, pc_write_cond, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_source, jump, mem_read, mem_write;
    logic [6:0]  alu_op;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state;

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .jump(jump),
        .mem_read(mem_read), .mem_write(mem_write), .illegal_op(illegal_op), .retired(retired),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  state;
        logic        ir_write, pc_write, pc_write_cond, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0]  alu_src_b;
        logic [6:0]  alu_op;
        logic [1:0]  pc_source, jump, mem_read, mem_write;
        logic        illegal_op;
        logic [31:0] retired;
    } obs_t;

    typedef struct {
        logic       rdy;
        logic       stl;
        logic [5:0] op;
        obs_t       e;
    } cyc_t;

    typedef struct {
        int op, fw, mw, len, regw, memr, memw;
    } row_t;

    localparam int C_R = 0, C_BR = 1, C_J = 2, C_JAL = 3, C_IMM = 4, C_LD = 5, C_ST = 6, C_ILL = 7;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ret;
    logic exp_ill;
    int   stall_pct;
    int   mem_stall;
    cyc_t q[$];
    row_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int cls(input int op);
        case (op)
            0:                 return C_R;
            1, 4, 5:           return C_BR;
            2:                 return C_J;
            3:                 return C_JAL;
            8, 10, 12, 13, 14: return C_IMM;
            32, 33, 35:        return C_LD;
            40, 41, 43:        return C_ST;
            default:           return C_ILL;
        endcase
    endfunction

    // low three opcode bits select byte/half/word for every load and store
    function automatic int size_of(input int op);
        return (op % 8 == 0) ? 1 : (op % 8 == 1) ? 2 : 3;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1));
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.state = state;            a.ir_write = ir_write;     a.pc_write = pc_write;
        a.pc_write_cond = pc_write_cond; a.i_or_d = i_or_d;   a.reg_write = reg_write;
        a.reg_dst = reg_dst;        a.mem_to_reg = mem_to_reg; a.alu_src_a = alu_src_a;
        a.alu_src_b = alu_src_b;    a.alu_op = alu_op;         a.pc_source = pc_source;
        a.jump = jump;              a.mem_read = mem_read;     a.mem_write = mem_write;
        a.illegal_op = illegal_op;  a.retired = retired;
        return a;
    endfunction

    function automatic obs_t blank(input state_t s);
        obs_t e;
        e = '0;
        e.state = s;
        e.retired = 32'(exp_ret);
        e.illegal_op = exp_ill;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stall(input logic [5:0] op, input obs_t e);
        cyc_t c;
        c.rdy = rnd(); c.stl = 1'b1; c.op = op; c.e = e;
        c.e.ir_write = 0; c.e.pc_write = 0; c.e.pc_write_cond = 0; c.e.reg_write = 0; c.e.mem_write = 0;
        q.push_back(c);
    endtask

    task automatic push(input logic rdy, input logic [5:0] op, input obs_t e);
        cyc_t c;
        if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
            for (int i = 0; i < $urandom_range(1, 2); i++) push_stall(op, e);
        end
        c.rdy = rdy; c.stl = 1'b0; c.op = op; c.e = e;
        q.push_back(c);
    endtask

    // Expected per-cycle outputs for one instruction, derived from its class.
    task automatic build(input int op, input int fw, input int mw);
        logic [5:0] o;
        logic [6:0] aimm;
        logic [1:0] sz;
        int         c;
        obs_t       e;
        o = 6'(op); aimm = {1'b1, o}; c = cls(op); sz = 2'(size_of(op));
        for (int i = 0; i < fw; i++) begin
            e = blank(ST_FETCH); e.mem_read = 3; e.alu_src_b = 1;
            push(1'b0, 6'($urandom), e);
        end
        e = blank(ST_FETCH); e.mem_read = 3; e.alu_src_b = 1; e.ir_write = 1; e.pc_write = 1;
        push(1'b1, 6'($urandom), e);
        e = blank(ST_DECODE); e.alu_src_b = 3;
        push(rnd(), o, e);
        case (c)
            C_R: begin
                e = blank(ST_EXEC_R); e.alu_src_a = 1; e.jump = 2; push(rnd(), o, e);
                e = blank(ST_WB_R); e.reg_write = 1; e.reg_dst = 1; e.jump = 2; push(rnd(), o, e);
                exp_ret++;
            end
            C_IMM: begin
                e = blank(ST_EXEC_I); e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = aimm; push(rnd(), o, e);
                e = blank(ST_WB_I); e.reg_write = 1; push(rnd(), o, e);
                exp_ret++;
            end
            C_LD, C_ST: begin
                e = blank(ST_MEM_ADDR); e.alu_src_b = 2; e.alu_op = aimm; push(rnd(), o, e);
                e = blank(c == C_LD ? ST_MEM_RD : ST_MEM_WR); e.i_or_d = 1;
                if (c == C_LD) e.mem_read = sz; else e.mem_write = sz;
                for (int i = 0; i < mem_stall; i++) push_stall(o, e);
                for (int i = 0; i < mw; i++) push(1'b0, o, e);
                push(1'b1, o, e);
                if (c == C_LD) begin
                    e = blank(ST_WB_MEM); e.reg_write = 1; e.mem_to_reg = 1; push(rnd(), o, e);
                end
                exp_ret++;
            end
            C_BR: begin
                e = blank(ST_BRANCH); e.pc_write_cond = 1; e.pc_source = 1; e.alu_op = aimm;
                push(rnd(), o, e);
                exp_ret++;
            end
            C_J, C_JAL: begin
                e = blank(ST_JUMP); e.pc_write = 1; e.pc_source = 2;
                e.jump = (c == C_JAL) ? 2'd1 : 2'd3; e.reg_write = (c == C_JAL);
                push(rnd(), o, e);
                exp_ret++;
            end
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                exp_ill = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    e = blank(ST_TRAP); push(rnd(), o, e);
                end
`else
                exp_ret++;
`endif
            end
        endcase
    endtask

    task automatic run_trace(input string nm);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.op; mem_ready = c.rdy; stall = c.stl;
            @(negedge clk);
            chk(nm, sample(), c.e);
            step();
        end
        stall = 1'b0; mem_ready = 1'b0;
    endtask

    // Table row: memory answers after fw (fetch) / mw (data) wait cycles; measure latency and strobes.
    task automatic run_row(input row_t r);
        int          cnt, cyc, regw, memr, memw;
        logic [31:0] r0;
        logic        req, rdy;
        cnt = 0; cyc = 0; regw = 0; memr = 0; memw = 0; r0 = retired;
        opcode = 6'(r.op);
        while (retired == r0 && cyc < 40) begin
            req = (mem_read != 0) || (mem_write != 0);
            rdy = req && (cnt >= (i_or_d ? r.mw : r.fw));
            mem_ready = rdy;
            @(negedge clk);
            if (reg_write) regw++;
            if (i_or_d && int'(mem_read) > memr) memr = int'(mem_read);
            if (int'(mem_write) > memw) memw = int'(mem_write);
            cnt = (req && !rdy) ? cnt + 1 : 0;
            step();
            cyc++;
        end
        mem_ready = 1'b0;
        exp_ret++;
        chk($sformatf("op%0d latency", r.op), 64'(cyc), 64'(r.len));
        chk($sformatf("op%0d reg_write pulses", r.op), 64'(regw), 64'(r.regw));
        chk($sformatf("op%0d mem_read size", r.op), 64'(memr), 64'(r.memr));
        chk($sformatf("op%0d mem_write size", r.op), 64'(memw), 64'(r.memw));
        chk($sformatf("op%0d retired", r.op), 64'(retired), 64'(exp_ret));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t e;
        int   legal[] = '{0, 1, 4, 5, 2, 3, 8, 10, 12, 13, 14, 32, 33, 35, 40, 41, 43};
        int   illeg[] = '{6, 7, 9, 15, 34, 63};
        int   op;

        //                 op fw mw len regw memr memw
        tbl.push_back(row_t'{ 0, 0, 0, 4, 1, 0, 0});
        tbl.push_back(row_t'{ 8, 1, 0, 5, 1, 0, 0});
        tbl.push_back(row_t'{35, 0, 2, 7, 1, 3, 0});
        tbl.push_back(row_t'{33, 0, 2, 7, 1, 2, 0});
        tbl.push_back(row_t'{32, 0, 0, 5, 1, 1, 0});
        tbl.push_back(row_t'{40, 0, 0, 4, 0, 0, 1});
        tbl.push_back(row_t'{41, 0, 0, 4, 0, 0, 2});
        tbl.push_back(row_t'{43, 2, 1, 7, 0, 0, 3});
        tbl.push_back(row_t'{ 4, 0, 0, 3, 0, 0, 0});
        tbl.push_back(row_t'{ 2, 0, 0, 3, 0, 0, 0});
        tbl.push_back(row_t'{ 3, 0, 0, 3, 1, 0, 0});
        tbl.push_back(row_t'{13, 0, 0, 4, 1, 0, 0});
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        tbl.push_back(row_t'{ 9, 0, 0, 2, 0, 0, 0});
`endif

        reset_n = 1'b0; opcode = '0; mem_ready = 1'b0; stall = 1'b0;
        exp_ret = 0; exp_ill = 1'b0; stall_pct = 0; mem_stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = blank(ST_FETCH); e.mem_read = 3; e.alu_src_b = 1;
        chk("reset outputs", sample(), e);
        step();
        reset_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i]);

        build(0, 0, 0);  run_trace("add trace");
        build(33, 0, 2); run_trace("lh 2-wait trace");
        build(40, 0, 0); run_trace("sb trace");
        build(3, 0, 0);  run_trace("jal trace");
        mem_stall = 3;
        build(40, 1, 0); run_trace("stall in MEM_WR");
        mem_stall = 0;

        stall_pct = 15;
        for (int n = 0; n < 40; n++) begin
            op = legal[$urandom_range(legal.size() - 1)];
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
            if ($urandom_range(7) == 0) op = illeg[$urandom_range(illeg.size() - 1)];
`endif
            build(op, $urandom_range(2), $urandom_range(2));
        end
        run_trace("random trace");
        stall_pct = 0;

        // reset in the middle of a load wait aborts it at once
        opcode = 6'd35; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        exp_ret = 0;
        e = blank(ST_FETCH); e.mem_read = 3; e.alu_src_b = 1;
        chk("reset mid-load", sample(), e);
        step();
        reset_n = 1'b1;
        build(35, 0, 0); run_trace("load after abort");

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        build(9, 0, 0); run_trace("illegal trap");
`else
        build(9, 0, 0); build(0, 0, 0); run_trace("illegal nop");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
